muldiv_hilo_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/div_radix2.sv | 57 +++++
 rtl/muldiv_hilo_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM states and op classifiers for the muldiv unit
package muldiv_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MADD  = 4'd4,
    MD_MADDU = 4'd5,
    MD_MSUB  = 4'd6,
    MD_MSUBU = 4'd7,
    MD_MTHI  = 4'd8,
    MD_MTLO  = 4'd9,
    MD_NOP   = 4'd10
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  function automatic logic is_mul(input md_op_e op);
    return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic is_signed(input md_op_e op);
    return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
  endfunction

endpackage

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - unsigned radix-2 restoring divider, one quotient bit per cycle
module div_radix2 #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cancel,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          ready
);

  localparam int CW = $clog2(DW + 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rem_q;
  logic [DW-1:0] quo_q;
  logic [DW-1:0] dvs_q;
  logic [DW:0]   partial;
  logic          ge;

  // quotient/remainder are the result of the step taken this cycle, so the
  // final values are visible combinationally while ready is high
  always_comb begin
    partial   = {rem_q, quo_q[DW-1]};
    ge        = partial >= {1'b0, dvs_q};
    remainder = ge ? (partial[DW-1:0] - dvs_q) : partial[DW-1:0];
    quotient  = {quo_q[DW-2:0], ge};
    ready     = busy && (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst || cancel) begin
      busy  <= 1'b0;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CW'(DW);
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (busy) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt   <= cnt - CW'(1);
      busy  <= (cnt != CW'(1));
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - multi-cycle mul/div/mac unit with private HI/LO pair and EX stall request
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int DW       = 32,
  parameter int MUL_STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  md_op_e        op,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic          cancel,
  output logic          stallreq,
  output logic          done,
  output logic [DW-1:0] hi_rdata,
  output logic [DW-1:0] lo_rdata
);

  localparam int CW         = $clog2(DW + 1);
  localparam int MUL_CYCLES = DW / MUL_STEP;

  md_state_e       state;
  logic [CW-1:0]   cnt;
  md_op_e          op_q;
  logic [DW-1:0]   a_q;
  logic            neg_prod;
  logic            neg_rem;
  logic            b_zero;
  logic [2*DW-1:0] mcand_q;
  logic [DW-1:0]   mplier_q;
  logic [2*DW-1:0] prod_q;
  logic [DW-1:0]   hi_q;
  logic [DW-1:0]   lo_q;

  logic            md_op;
  logic            a_neg_in;
  logic            b_neg_in;
  logic [DW-1:0]   a_mag;
  logic [DW-1:0]   b_mag;
  logic            div_start;
  logic [DW-1:0]   div_quo;
  logic [DW-1:0]   div_rem;
  logic            div_ready;
  logic            finish;
  logic [2*DW-1:0] part;
  logic [2*DW-1:0] prod_next;
  logic [2*DW-1:0] prod_fix;
  logic [2*DW-1:0] mul_res;
  logic [DW-1:0]   quo_fix;
  logic [DW-1:0]   rem_fix;
  logic [2*DW-1:0] div_res;

  always_comb begin
    md_op     = is_mul(op) || is_div(op);
    a_neg_in  = is_signed(op) && src_a[DW-1];
    b_neg_in  = is_signed(op) && src_b[DW-1];
    a_mag     = a_neg_in ? -src_a : src_a;
    b_mag     = b_neg_in ? -src_b : src_b;
    div_start = (state == S_IDLE) && op_valid && !cancel && is_div(op);
    stallreq  = !rst && !cancel &&
                ((state == S_RUN) || ((state == S_IDLE) && op_valid && md_op));
    finish    = (state == S_RUN) && (is_div(op_q) ? div_ready : (cnt == CW'(1)));
  end

  // shift-add over MUL_STEP multiplier bits; sign and accumulate are applied
  // to the final product on the same edge that writes HI/LO
  always_comb begin
    part = '0;
    for (int j = 0; j < MUL_STEP; j++)
      if (mplier_q[j]) part = part + (mcand_q << j);
    prod_next = prod_q + part;
    prod_fix  = neg_prod ? -prod_next : prod_next;
    case (op_q)
      MD_MADD, MD_MADDU: mul_res = {hi_q, lo_q} + prod_fix;
      MD_MSUB, MD_MSUBU: mul_res = {hi_q, lo_q} - prod_fix;
      default:           mul_res = prod_fix;
    endcase
    quo_fix = neg_prod ? -div_quo : div_quo;
    rem_fix = neg_rem ? -div_rem : div_rem;
    div_res = b_zero ? {a_q, {DW{1'b1}}} : {rem_fix, quo_fix};
  end

  div_radix2 #(.DW(DW)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .cancel    (cancel),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .ready     (div_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= MD_NOP;
      a_q      <= '0;
      neg_prod <= 1'b0;
      neg_rem  <= 1'b0;
      b_zero   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (op_valid) begin
              if (op == MD_MTHI) begin
                hi_q <= src_a;
              end else if (op == MD_MTLO) begin
                lo_q <= src_a;
              end else if (md_op) begin
                state    <= S_RUN;
                cnt      <= is_div(op) ? CW'(DW) : CW'(MUL_CYCLES);
                op_q     <= op;
                a_q      <= src_a;
                neg_prod <= a_neg_in ^ b_neg_in;
                neg_rem  <= a_neg_in;
                b_zero   <= (src_b == '0);
                mcand_q  <= {{DW{1'b0}}, a_mag};
                mplier_q <= b_mag;
                prod_q   <= '0;
              end
            end
          end
          S_RUN: begin
            cnt      <= cnt - CW'(1);
            mcand_q  <= mcand_q << MUL_STEP;
            mplier_q <= mplier_q >> MUL_STEP;
            prod_q   <= prod_next;
            if (finish) begin
              {hi_q, lo_q} <= is_div(op_q) ? div_res : mul_res;
              state        <= S_DONE;
              done         <= 1'b1;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb/tb_muldiv_hilo_unit.sv - vector table, corner sequences and random ops against an arithmetic model
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op_valid_v;
  md_op_e      op;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic        stall0, stall1, done0, done1;
  logic [31:0] hi0, lo0, hi1, lo1;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi[2];
  logic [31:0] m_lo[2];

  always #5 clk = ~clk;

  muldiv_hilo_unit #(.DW(32), .MUL_STEP(1)) u_md1 (
    .clk(clk), .rst(rst), .op_valid(op_valid_v[0]), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .stallreq(stall0), .done(done0), .hi_rdata(hi0), .lo_rdata(lo0)
  );

  muldiv_hilo_unit #(.DW(32), .MUL_STEP(4)) u_md4 (
    .clk(clk), .rst(rst), .op_valid(op_valid_v[1]), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .stallreq(stall1), .done(done1), .hi_rdata(hi1), .lo_rdata(lo1)
  );

  typedef struct {
    int          u;
    md_op_e      op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          exp_stall;
  } vec_t;

  vec_t tbl[12];

  function automatic logic stall_of(input int u);
    return (u == 0) ? stall0 : stall1;
  endfunction

  function automatic logic done_of(input int u);
    return (u == 0) ? done0 : done1;
  endfunction

  function automatic logic [63:0] hilo_of(input int u);
    return (u == 0) ? {hi0, lo0} : {hi1, lo1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input md_op_e o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] sp, up;
    int qa, qb;
    sp = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    up = {32'b0, a} * {32'b0, b};
    qa = $signed(a);
    qb = $signed(b);
    case (o)
      MD_MULT:  return sp;
      MD_MULTU: return up;
      MD_MADD:  return acc + sp;
      MD_MADDU: return acc + up;
      MD_MSUB:  return acc - sp;
      MD_MSUBU: return acc - up;
      MD_DIVU:  return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(qa % qb), 32'(qa / qb)};
      end
      default:  return acc;
    endcase
  endfunction

  function automatic int ref_stall(input int u, input md_op_e o);
    if (o == MD_DIV || o == MD_DIVU) return 33;
    return (u == 0) ? 33 : 9;
  endfunction

  task automatic write_hilo(input int u, input md_op_e o, input logic [31:0] val);
    @(negedge clk);
    op = o; src_a = val; src_b = 32'h0; op_valid_v = 2'b00; op_valid_v[u] = 1'b1;
    #1 check("mt_nostall", {63'b0, stall_of(u)}, 64'd0);
    @(negedge clk);
    op_valid_v = 2'b00;
    if (o == MD_MTHI) m_hi[u] = val; else m_lo[u] = val;
  endtask

  // holds op_valid through the DONE cycle, then checks that nothing restarts
  task automatic run_op(input int u, input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int early);
    @(negedge clk);
    op = o; src_a = a; src_b = b; op_valid_v = 2'b00; op_valid_v[u] = 1'b1;
    stalls = 0; early = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stall_of(u)) break;
      stalls++;
      if (done_of(u)) early++;
      @(negedge clk);
    end
    check("done_pulse", {63'b0, done_of(u)}, 64'd1);
    @(negedge clk);
    op_valid_v = 2'b00;
    #1 check("no_restart", {62'b0, stall_of(u), done_of(u)}, 64'd0);
  endtask

  task automatic exec_and_check(input string tag, input int u, input md_op_e o,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] exp, input int exp_stall);
    int stalls, early;
    run_op(u, o, a, b, stalls, early);
    check({tag, "_stall"}, 64'(stalls), 64'(exp_stall));
    check({tag, "_early_done"}, 64'(early), 64'd0);
    check({tag, "_hilo"}, hilo_of(u), exp);
    {m_hi[u], m_lo[u]} = exp;
  endtask

  initial begin
    int          u, pd, cyc;
    md_op_e      o;
    logic [31:0] a, b;

    tbl[0]  = '{0, MD_MULT,  32'd7,        32'hFFFFFFF9, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFCF, 33};
    tbl[1]  = '{0, MD_DIVU,  32'd100,      32'd7,        32'h0,        32'h0,        32'd2,        32'd14,       33};
    tbl[2]  = '{0, MD_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    tbl[3]  = '{0, MD_DIVU,  32'd5,        32'd0,        32'h0,        32'h0,        32'd5,        32'hFFFFFFFF, 33};
    tbl[4]  = '{0, MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'h80000000, 33};
    tbl[5]  = '{0, MD_MADD,  32'd3,        32'd4,        32'h0,        32'h10,       32'h0,        32'h1C,       33};
    tbl[6]  = '{0, MD_MSUB,  32'd3,        32'd8,        32'h0,        32'h10,       32'hFFFFFFFF, 32'hFFFFFFF8, 33};
    tbl[7]  = '{1, MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000001, 9};
    tbl[8]  = '{1, MD_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    tbl[9]  = '{0, MD_DIV,   32'hFFFFFFF0, 32'd0,        32'h0,        32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF, 33};
    tbl[10] = '{1, MD_MSUBU, 32'd2,        32'd3,        32'h1,        32'h0,        32'h0,        32'hFFFFFFFA, 9};
    tbl[11] = '{0, MD_MADDU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFD, 33};

    rst = 1'b1; op_valid_v = 2'b00; op = MD_NOP; src_a = '0; src_b = '0; cancel = 1'b0;
    m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_hilo0", {hi0, lo0}, 64'd0);
    check("reset_hilo1", {hi1, lo1}, 64'd0);
    check("reset_outs", {60'b0, stall0, stall1, done0, done1}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      write_hilo(tbl[i].u, MD_MTHI, tbl[i].pre_hi);
      write_hilo(tbl[i].u, MD_MTLO, tbl[i].pre_lo);
      check($sformatf("vec%0d_preload", i), hilo_of(tbl[i].u), {tbl[i].pre_hi, tbl[i].pre_lo});
      exec_and_check($sformatf("vec%0d", i), tbl[i].u, tbl[i].op, tbl[i].a, tbl[i].b,
                     {tbl[i].exp_hi, tbl[i].exp_lo}, tbl[i].exp_stall);
    end

    // cancel in the middle of a divide
    write_hilo(0, MD_MTHI, 32'h0000AAAA);
    write_hilo(0, MD_MTLO, 32'h00005555);
    @(negedge clk);
    op = MD_DIV; src_a = 32'd1000; src_b = 32'd3; op_valid_v = 2'b01;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    #1 check("cancel_stall_drop", {63'b0, stall0}, 64'd0);
    @(negedge clk);
    cancel = 1'b0; op_valid_v = 2'b00;
    #1 check("cancel_idle", {62'b0, stall0, done0}, 64'd0);
    pd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done0 || stall0) pd++;
    end
    check("cancel_quiet", 64'(pd), 64'd0);
    check("cancel_hilo", {hi0, lo0}, {m_hi[0], m_lo[0]});

    // cancel on the cycle whose edge would write HI/LO
    write_hilo(1, MD_MTHI, 32'h12345678);
    write_hilo(1, MD_MTLO, 32'h9ABCDEF0);
    @(negedge clk);
    op = MD_MULTU; src_a = 32'd11; src_b = 32'd13; op_valid_v = 2'b10;
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0; op_valid_v = 2'b00;
    #1 check("cancel_last_done", {62'b0, stall1, done1}, 64'd0);
    check("cancel_last_hilo", {hi1, lo1}, {m_hi[1], m_lo[1]});

    // cancel alongside MTHI in IDLE
    @(negedge clk);
    op = MD_MTHI; src_a = 32'hDEADBEEF; op_valid_v = 2'b01; cancel = 1'b1;
    @(negedge clk);
    op_valid_v = 2'b00; cancel = 1'b0;
    #1 check("cancel_mthi", {hi0, lo0}, {m_hi[0], m_lo[0]});

    // NOP and undefined codes do nothing
    for (int c = 10; c < 16; c++) begin
      @(negedge clk);
      op = md_op_e'(4'(c)); src_a = $urandom; src_b = $urandom; op_valid_v = 2'b11;
      #1 check($sformatf("undef%0d_stall", c), {62'b0, stall0, stall1}, 64'd0);
      @(negedge clk);
      op_valid_v = 2'b00;
      #1 check($sformatf("undef%0d_hilo", c), {hi0, lo0, hi1, lo1} == {m_hi[0], m_lo[0], m_hi[1], m_lo[1]}, 64'd1);
    end

    for (int n = 0; n < 60; n++) begin
      u = $urandom_range(0, 1);
      o = md_op_e'(4'($urandom_range(0, 9)));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      if (o == MD_MTHI || o == MD_MTLO) begin
        write_hilo(u, o, a);
        check($sformatf("rnd%0d_mt", n), hilo_of(u), {m_hi[u], m_lo[u]});
      end else begin
        exec_and_check($sformatf("rnd%0d", n), u, o, a, b,
                       ref_result(o, a, b, {m_hi[u], m_lo[u]}), ref_stall(u, o));
      end
    end

    // reset in the middle of a multiply
    write_hilo(0, MD_MTHI, 32'h11111111);
    write_hilo(0, MD_MTLO, 32'h22222222);
    @(negedge clk);
    op = MD_MULT; src_a = 32'd9; src_b = 32'd9; op_valid_v = 2'b01;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; op_valid_v = 2'b00;
    #1 check("rst_run_hilo", {hi0, lo0}, 64'd0);
    pd = 0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done0 || stall0) pd++;
      cyc++;
    end
    check("rst_run_quiet", 64'(pd), 64'd0);
    check("rst_run_hilo_after", {hi0, lo0, 32'(cyc)}, {64'd0, 32'd40});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
